// File: rtl/conv_collector.sv
// conv_collector: buffers one activation map of convolver results and replays
// it in write order over a valid/ready read port, marking row ends and the
// final sample.
// Optional feature: define COLLECT_MAX_EN to track the running signed maximum
// of captured samples on max_out; left undefined, max_out is tied to zero.
// Ports:
//   clk, global_rst_n         clock (rising edge), async active-low reset
//   start                     one-cycle pulse, arms a new collection (highest priority)
//   in_valid, data_in         convolver result strobe and 8-bit sample
//   end_activate              level, convolver finished the map
//   rd_valid, rd_ready        read-side handshake
//   rd_data                   buffered sample
//   rd_row_end, rd_last       row boundary / final sample markers
//   done                      map fully drained (held until start)
//   overflow                  sticky dropped-sample flag
//   count                     samples captured in the current map
//   max_out                   running signed maximum (COLLECT_MAX_EN only)
module conv_collector #(
   parameter int unsigned OUTLENPER = 61,
   parameter int unsigned OUTLENALL = 2562
) (
   input  logic        clk,
   input  logic        global_rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  data_in,
   input  logic        end_activate,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [7:0]  rd_data,
   output logic        rd_row_end,
   output logic        rd_last,
   output logic        done,
   output logic        overflow,
   output logic [11:0] count,
   output logic [7:0]  max_out
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 12;
   localparam int unsigned AW = (OUTLENALL > 1) ? $clog2(OUTLENALL) : 1;
   localparam int unsigned PW = (OUTLENPER > 1) ? $clog2(OUTLENPER) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(OUTLENALL);
   localparam logic [PW-1:0] LAST_COL = PW'(OUTLENPER - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] rd_idx_q, rd_idx_d;   // index of the sample currently presented
   logic [PW-1:0] col_q, col_d;         // rd_idx mod OUTLENPER, kept incrementally
   logic          rd_valid_q, rd_valid_d;
   logic          rd_row_end_q, rd_row_end_d;
   logic          rd_last_q, rd_last_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] mem_q [OUTLENALL];

   logic          wr_en_c;
   logic          rd_load_c;
   logic [AW-1:0] rd_addr_c;

   // Next-state and read-prefetch control.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      rd_idx_d     = rd_idx_q;
      col_d        = col_q;
      rd_valid_d   = rd_valid_q;
      rd_row_end_d = rd_row_end_q;
      rd_last_d    = rd_last_q;
      done_d       = done_q;
      ovf_d        = ovf_q;
      wr_en_c      = 1'b0;
      rd_load_c    = 1'b0;
      rd_addr_c    = '0;

      if (start) begin
         state_d      = S_COLLECT;
         count_d      = '0;
         rd_idx_d     = '0;
         col_d        = '0;
         rd_valid_d   = 1'b0;
         rd_row_end_d = 1'b0;
         rd_last_d    = 1'b0;
         done_d       = 1'b0;
         ovf_d        = 1'b0;
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (in_valid) begin
                  if (count_q < FULL_CNT) begin
                     wr_en_c = 1'b1;
                     count_d = count_q + CW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               // Decide on the post-capture count so a same-edge sample is kept.
               if (count_d == FULL_CNT) begin
                  state_d = S_DRAIN;
               end else if (end_activate) begin
                  if (count_d == '0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               ovf_d = ovf_q | in_valid;
               if (!rd_valid_q) begin
                  // First cycle in DRAIN: fetch buffer[0].
                  rd_load_c    = 1'b1;
                  rd_addr_c    = '0;
                  rd_idx_d     = '0;
                  col_d        = '0;
                  rd_valid_d   = 1'b1;
                  rd_row_end_d = (LAST_COL == '0);
                  rd_last_d    = (count_q == CW'(1));
               end else if (rd_ready) begin
                  if (rd_last_q) begin
                     rd_valid_d   = 1'b0;
                     rd_row_end_d = 1'b0;
                     rd_last_d    = 1'b0;
                     state_d      = S_DONE;
                     done_d       = 1'b1;
                  end else begin
                     // Fetch the next sample on the handshake edge: no bubble.
                     rd_load_c    = 1'b1;
                     rd_idx_d     = rd_idx_q + CW'(1);
                     rd_addr_c    = AW'(rd_idx_d);
                     col_d        = (col_q == LAST_COL) ? '0 : col_q + PW'(1);
                     rd_row_end_d = (col_d == LAST_COL);
                     rd_last_d    = (rd_idx_d == count_q - CW'(1));
                  end
               end
            end
            default: begin
               ovf_d = ovf_q | in_valid;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         rd_idx_q     <= '0;
         col_q        <= '0;
         rd_valid_q   <= 1'b0;
         rd_row_end_q <= 1'b0;
         rd_last_q    <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rd_idx_q     <= rd_idx_d;
         col_q        <= col_d;
         rd_valid_q   <= rd_valid_d;
         rd_row_end_q <= rd_row_end_d;
         rd_last_q    <= rd_last_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         if (rd_load_c) begin
            rd_data_q <= mem_q[rd_addr_c];
         end
      end
   end

   // Sample buffer; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[AW'(count_q)] <= data_in;
      end
   end

`ifdef COLLECT_MAX_EN
   logic [DW-1:0] max_q;

   // Running signed maximum over captured samples, seeded with zero.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         max_q <= '0;
      end else if (start) begin
         max_q <= '0;
      end else if (wr_en_c && ($signed(data_in) > $signed(max_q))) begin
         max_q <= data_in;
      end
   end

   assign max_out = max_q;
`else
   assign max_out = '0;
`endif

   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_row_end = rd_row_end_q;
   assign rd_last    = rd_last_q;
   assign done       = done_q;
   assign overflow   = ovf_q;
   assign count      = count_q;

endmodule
